// File: rtl/rc4_key_search_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rc4_key_search_ctrl : brute-force RC4 key search sequencer (key bus owner,
//                       arcfour KSA and decrypt/check engine handshakes)
// Rev 1.0
// ----------------------------------------------------------------------------
module rc4_key_search_ctrl #(
  parameter int                  RAM_WIDTH  = 8,
  parameter int                  KEY_LENGTH = 3,
  parameter int                  KEY_BITS   = 22,
  parameter logic [KEY_BITS-1:0] START_KEY  = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 ksa_finished,
  input  logic                                 dec_done,
  input  logic                                 dec_valid,
  output logic                                 ksa_start,
  output logic                                 dec_start,
  output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
  output logic [KEY_BITS:0]                    attempts,
  output logic                                 busy,
  output logic                                 found,
  output logic                                 exhausted,
  output logic [2:0]                           state_tap
);

  localparam int                  C_KEY_W    = KEY_LENGTH * RAM_WIDTH;
  localparam logic [KEY_BITS-1:0] C_KEY_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_KSA_START = 3'd1,
    S_KSA_ARM   = 3'd2,
    S_KSA_WAIT  = 3'd3,
    S_DEC_START = 3'd4,
    S_DEC_WAIT  = 3'd5,
    S_NEXT_KEY  = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [KEY_BITS-1:0] r_key;
  logic [KEY_BITS:0]   r_attempts;
  logic                r_ksa_start;
  logic                r_dec_start;
  logic                r_busy;
  logic                r_found;
  logic                r_exhausted;

  logic w_load_key;
  logic w_inc_key;
  logic w_inc_att;
  logic w_set_found;
  logic w_set_exh;
  logic w_clr_flags;

  always_comb begin
    w_next_state = r_state;
    w_load_key   = 1'b0;
    w_inc_key    = 1'b0;
    w_inc_att    = 1'b0;
    w_set_found  = 1'b0;
    w_set_exh    = 1'b0;
    w_clr_flags  = 1'b0;
    if (abort && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
      w_clr_flags  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_next_state = S_KSA_START;
            w_load_key   = 1'b1;
          end
        end
        S_KSA_START: w_next_state = S_KSA_ARM;
        // finished may still be high from the previous run; wait for its drop
        S_KSA_ARM: begin
          if (!ksa_finished) w_next_state = S_KSA_WAIT;
        end
        S_KSA_WAIT: begin
          if (ksa_finished) w_next_state = S_DEC_START;
        end
        S_DEC_START: w_next_state = S_DEC_WAIT;
        S_DEC_WAIT: begin
          if (dec_done) begin
            w_inc_att = 1'b1;
            if (dec_valid) begin
              w_next_state = S_DONE;
              w_set_found  = 1'b1;
            end else begin
              w_next_state = S_NEXT_KEY;
            end
          end
        end
        S_NEXT_KEY: begin
          if (r_key == C_KEY_LAST) begin
            w_next_state = S_DONE;
            w_set_exh    = 1'b1;
          end else begin
            w_next_state = S_KSA_START;
            w_inc_key    = 1'b1;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Pulses and busy are decoded from the next state so they line up with the state itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ksa_start <= 1'b0;
      r_dec_start <= 1'b0;
      r_busy      <= 1'b0;
      r_key       <= '0;
      r_attempts  <= '0;
      r_found     <= 1'b0;
      r_exhausted <= 1'b0;
    end else begin
      r_ksa_start <= (w_next_state == S_KSA_START);
      r_dec_start <= (w_next_state == S_DEC_START);
      r_busy      <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
      if (w_load_key) begin
        r_key      <= START_KEY;
        r_attempts <= '0;
      end else begin
        if (w_inc_key) r_key <= r_key + KEY_BITS'(1);
        if (w_inc_att) r_attempts <= r_attempts + (KEY_BITS + 1)'(1);
      end
      if (w_load_key || w_clr_flags) begin
        r_found     <= 1'b0;
        r_exhausted <= 1'b0;
      end else begin
        if (w_set_found) r_found <= 1'b1;
        if (w_set_exh) r_exhausted <= 1'b1;
      end
    end
  end

  assign ksa_start = r_ksa_start;
  assign dec_start = r_dec_start;
  assign key       = C_KEY_W'(r_key);
  assign attempts  = r_attempts;
  assign busy      = r_busy;
  assign found     = r_found;
  assign exhausted = r_exhausted;
  assign state_tap = r_state;

endmodule
`default_nettype wire

// File: tb/tb_rc4_key_search_ctrl.sv
`default_nettype none
// tb_rc4_key_search_ctrl : directed bench with KSA/decrypt responder models and
// a key scoreboard checked on every ksa_start and dec_start pulse.
module tb_rc4_key_search_ctrl;

  logic clk = 1'b0;
  logic reset, start, abort, ksa_finished, dec_done, dec_valid;
  logic ksa_start, dec_start, busy, found, exhausted;
  logic [2:0][7:0] key;
  logic [3:0]  attempts;
  logic [2:0]  state_tap;
  logic [23:0] key_flat;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned q_ksa[$];
  int unsigned q_dec[$];

  int          drop_dly  = 1;
  int          rise_dly  = 3;
  int          dec_dly   = 2;
  bit          dec_auto  = 1'b1;
  bit          valid_en  = 1'b0;
  logic [23:0] valid_key = '0;

  int ksa_cnt = 0;
  bit ksa_act = 1'b0;
  int dec_cnt = 0;
  bit dec_act = 1'b0;

  // Small key space so exhaustion is reachable quickly
  rc4_key_search_ctrl #(
    .RAM_WIDTH (8),
    .KEY_LENGTH(3),
    .KEY_BITS  (3),
    .START_KEY (3'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .ksa_finished(ksa_finished),
    .dec_done    (dec_done),
    .dec_valid   (dec_valid),
    .ksa_start   (ksa_start),
    .dec_start   (dec_start),
    .key         (key),
    .attempts    (attempts),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .state_tap   (state_tap)
  );

  assign key_flat = key;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state_tap !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, state_tap, s);
  endtask

  task automatic wait_state_key(input logic [2:0] s, input logic [23:0] k, input int budget,
                                input string tag);
    int n = 0;
    while (!(state_tap === s && key_flat === k) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {5'd0, state_tap, key_flat}, {5'd0, s, k});
  endtask

  // Scoreboard: every start pulse must present the next expected candidate key
  always @(negedge clk) begin
    if (ksa_start === 1'b1)
      check("ksa_key", key_flat, (q_ksa.size() != 0) ? q_ksa.pop_front() : 32'hDEAD_BEEF);
    if (dec_start === 1'b1)
      check("dec_key", key_flat, (q_dec.size() != 0) ? q_dec.pop_front() : 32'hDEAD_BEEF);
  end

  // arcfour model: finished drops drop_dly cycles after start, rises rise_dly later
  always @(negedge clk) begin
    if (ksa_start === 1'b1) begin
      ksa_cnt = 0;
      ksa_act = 1'b1;
    end else if (ksa_act) begin
      ksa_cnt++;
      if (ksa_cnt == drop_dly) ksa_finished = 1'b0;
      if (ksa_cnt == drop_dly + rise_dly) begin
        ksa_finished = 1'b1;
        ksa_act      = 1'b0;
      end
    end
  end

  // decrypt engine model: one-cycle done pulse dec_dly cycles after dec_start
  always @(negedge clk) begin
    if (!dec_auto) begin
      dec_act = 1'b0;
    end else begin
      dec_done  = 1'b0;
      dec_valid = 1'b0;
      if (dec_start === 1'b1) begin
        dec_cnt = 0;
        dec_act = 1'b1;
      end else if (dec_act) begin
        dec_cnt++;
        if (dec_cnt == dec_dly) begin
          dec_done  = 1'b1;
          dec_valid = valid_en && (key_flat == valid_key);
          dec_act   = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    ksa_finished = 1'b1; dec_done = 1'b0; dec_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_tap, 3'd0);
    check("rst_key", key_flat, 24'd0);
    check("rst_attempts", attempts, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_found", found, 1'b0);
    check("rst_exh", exhausted, 1'b0);
    check("rst_pulses", {ksa_start, dec_start}, 2'b00);
    reset = 1'b0;
    @(negedge clk);

    // Exhaust the whole space
    valid_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      q_ksa.push_back(k);
      q_dec.push_back(k);
    end
    pulse_start();
    check("t1_busy", busy, 1'b1);
    wait_state(3'd7, 1000, "t1_done_state");
    check("t1_exh", exhausted, 1'b1);
    check("t1_found", found, 1'b0);
    check("t1_key", key_flat, 24'd7);
    check("t1_attempts", attempts, 4'd8);
    check("t1_busy_end", busy, 1'b0);
    check("t1_q_ksa", q_ksa.size(), 0);
    check("t1_q_dec", q_dec.size(), 0);

    // Restart from DONE, key 5 is the valid one
    valid_en  = 1'b1;
    valid_key = 24'd5;
    for (int k = 0; k < 6; k++) begin
      q_ksa.push_back(k);
      q_dec.push_back(k);
    end
    pulse_start();
    check("t2_exh_cleared", exhausted, 1'b0);
    wait_state(3'd7, 1000, "t2_done_state");
    check("t2_found", found, 1'b1);
    check("t2_exh", exhausted, 1'b0);
    check("t2_key", key_flat, 24'h000005);
    check("t2_attempts", attempts, 4'd6);
    check("t2_q_dec", q_dec.size(), 0);

    // Stale finished high at start: drop 3 cycles after ksa_start, rise 10 later
    valid_key = 24'd0;
    drop_dly  = 3;
    rise_dly  = 10;
    q_ksa.push_back(0);
    q_dec.push_back(0);
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("t3_state_%0d", i), state_tap,
            (i == 0) ? 3'd1 : (i <= 3) ? 3'd2 : (i <= 13) ? 3'd3 : 3'd4);
      check($sformatf("t3_dec_start_%0d", i), dec_start, (i == 14) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    wait_state(3'd7, 100, "t3_done_state");
    check("t3_found", found, 1'b1);
    check("t3_attempts", attempts, 4'd1);
    drop_dly = 1;
    rise_dly = 3;

    // Abort during KSA_WAIT of key 2
    valid_en = 1'b0;
    for (int k = 0; k < 3; k++) q_ksa.push_back(k);
    for (int k = 0; k < 2; k++) q_dec.push_back(k);
    pulse_start();
    wait_state_key(3'd3, 24'd2, 300, "t4_reach_wait");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_state", state_tap, 3'd0);
    check("t4_busy", busy, 1'b0);
    check("t4_key", key_flat, 24'd2);
    check("t4_attempts", attempts, 4'd2);
    check("t4_flags", {found, exhausted}, 2'b00);
    repeat (20) @(negedge clk);
    check("t4_state_idle", state_tap, 3'd0);
    check("t4_q_dec", q_dec.size(), 0);

    // Abort and a valid verdict in the same cycle
    dec_auto = 1'b0;
    q_ksa.push_back(0);
    q_dec.push_back(0);
    pulse_start();
    wait_state(3'd5, 100, "t6_reach_decwait");
    dec_done  = 1'b1;
    dec_valid = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    dec_done  = 1'b0;
    dec_valid = 1'b0;
    abort     = 1'b0;
    check("t6_state", state_tap, 3'd0);
    check("t6_found", found, 1'b0);
    check("t6_attempts", attempts, 4'd0);
    check("t6_busy", busy, 1'b0);

    // Asynchronous reset between edges while in DEC_WAIT of key 2
    dec_auto = 1'b1;
    for (int k = 0; k < 3; k++) begin
      q_ksa.push_back(k);
      q_dec.push_back(k);
    end
    pulse_start();
    wait_state_key(3'd5, 24'd2, 300, "t5_reach_decwait");
    dec_auto = 1'b0;
    check("t5_pre_attempts", attempts, 4'd2);
    #2 reset = 1'b1;
    #1;
    check("t5_state", state_tap, 3'd0);
    check("t5_key", key_flat, 24'd0);
    check("t5_attempts", attempts, 4'd0);
    check("t5_busy", busy, 1'b0);
    check("t5_flags", {found, exhausted}, 2'b00);
    check("t5_pulses", {ksa_start, dec_start}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    check("t5_q_ksa", q_ksa.size(), 0);
    check("t5_q_dec", q_dec.size(), 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
